stage_wb: RTL

//  Writeback/commit stage after the TL stage. Retires one instruction per cycle:
//  - register-file write, store commit into the D-cache and branch/jump redirect.
//  - TLB writes and IRET.
//  - Precise per-thread exceptions on I-/D-TLB miss.

---
 rtl/stage_wb.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/stage_wb.sv
// Writeback/commit stage: register writeback, store commit, TLB writes, redirects and precise
// per-thread TLB-miss/illegal exceptions. Optional per-thread retire counters via WB_RETIRE_CNT_EN.
`timescale 1ns/1ps
module stage_wb #(
    parameter int          N_THREADS  = 4,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_2000,
    parameter int          PAGE_BITS  = 12,
    localparam int         THREAD_W   = $clog2(N_THREADS),
    localparam int         REG_W      = 5,
    localparam int         PADDR_W    = 32,
    localparam int         VPN_W      = 32 - PAGE_BITS,
    localparam int         PPN_W      = PADDR_W - PAGE_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [THREAD_W-1:0]  tl_thread,
    input  logic                 tl_isvalid,
    input  logic                 tl_itlb_miss,
    input  logic                 tl_dtlb_miss,
    input  logic [REG_W-1:0]     tl_dst,
    input  logic [31:0]          tl_pc,
    input  logic [31:0]          tl_r2,
    input  logic [31:0]          tl_data,
    input  logic [PADDR_W-1:0]   tl_paddr,
    input  logic                 tl_isequal,
    input  logic [31:0]          tl_mul,
    input  logic                 tl_flag_mul,
    input  logic                 tl_flag_reg,
    input  logic                 tl_flag_jump,
    input  logic                 tl_flag_branch,
    input  logic                 tl_flag_iret,
    input  logic                 tl_flag_store,
    input  logic                 tl_flag_isbyte,
    input  logic [1:0]           tl_flag_tlbwrite,
    output logic                 rf_wen,
    output logic [THREAD_W-1:0]  rf_thread,
    output logic [REG_W-1:0]     rf_dst,
    output logic [31:0]          rf_data,
    output logic                 store_en,
    output logic                 store_isbyte,
    output logic [PADDR_W-1:0]   store_addr,
    output logic [31:0]          store_data,
    output logic                 itlb_wen,
    output logic                 dtlb_wen,
    output logic [VPN_W-1:0]     tlb_vpn,
    output logic [PPN_W-1:0]     tlb_ppn,
    output logic                 redirect_en,
    output logic [THREAD_W-1:0]  redirect_thread,
    output logic [31:0]          redirect_pc,
    output logic [N_THREADS-1:0] mode
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [N_THREADS*32-1:0] retire_cnt
`endif
);

    logic [31:0] rm0 [N_THREADS];
    logic [31:0] rm1 [N_THREADS];
    logic [31:0] rm2 [N_THREADS];

    logic        illegal_p0;
    logic        exc_p0;
    logic        commit_p0;
    logic [31:0] cause_p0;

    // Stage p0: classify the incoming instruction (TLB misses outrank privilege violations)
    always_comb begin
        illegal_p0 = tl_isvalid && !mode[tl_thread] && (tl_flag_iret || (tl_flag_tlbwrite != 2'd0));
        exc_p0     = tl_itlb_miss || tl_dtlb_miss || illegal_p0;
        commit_p0  = tl_isvalid && !exc_p0;
        if (tl_itlb_miss)      cause_p0 = 32'd1;
        else if (tl_dtlb_miss) cause_p0 = 32'd2;
        else                   cause_p0 = 32'd3;
    end

    // Stage p1: registered commit outputs and architectural thread state
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen          <= 1'b0;
            rf_thread       <= '0;
            rf_dst          <= '0;
            rf_data         <= '0;
            store_en        <= 1'b0;
            store_isbyte    <= 1'b0;
            store_addr      <= '0;
            store_data      <= '0;
            itlb_wen        <= 1'b0;
            dtlb_wen        <= 1'b0;
            tlb_vpn         <= '0;
            tlb_ppn         <= '0;
            redirect_en     <= 1'b0;
            redirect_thread <= '0;
            redirect_pc     <= '0;
            mode            <= '1;
            for (int i = 0; i < N_THREADS; i++) begin
                rm0[i] <= '0;
                rm1[i] <= '0;
                rm2[i] <= '0;
            end
        end else begin
            rf_wen          <= 1'b0;
            store_en        <= 1'b0;
            itlb_wen        <= 1'b0;
            dtlb_wen        <= 1'b0;
            redirect_en     <= 1'b0;
            rf_thread       <= tl_thread;
            rf_dst          <= tl_dst;
            rf_data         <= tl_flag_mul ? tl_mul : tl_data;
            store_isbyte    <= tl_flag_isbyte;
            store_addr      <= tl_paddr;
            store_data      <= tl_r2;
            tlb_vpn         <= tl_data[31:PAGE_BITS];
            tlb_ppn         <= tl_r2[PPN_W-1:0];
            redirect_thread <= tl_thread;
            redirect_pc     <= tl_data;
            if (exc_p0) begin
                rm0[tl_thread]  <= tl_pc;
                rm1[tl_thread]  <= tl_itlb_miss ? tl_pc : tl_data;
                rm2[tl_thread]  <= cause_p0;
                mode[tl_thread] <= 1'b1;
                redirect_en     <= 1'b1;
                redirect_pc     <= EXC_VECTOR;
            end else if (tl_isvalid) begin
                rf_wen   <= tl_flag_reg;
                store_en <= tl_flag_store;
                itlb_wen <= (tl_flag_tlbwrite == 2'd1);
                dtlb_wen <= (tl_flag_tlbwrite == 2'd2);
                if (tl_flag_iret) begin
                    // only reachable in supervisor; user iret was trapped above
                    mode[tl_thread] <= 1'b0;
                    redirect_en     <= 1'b1;
                    redirect_pc     <= rm0[tl_thread];
                end else if (tl_flag_jump || (tl_flag_branch && tl_isequal)) begin
                    redirect_en <= 1'b1;
                end
            end
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] cnt [N_THREADS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_THREADS; i++) cnt[i] <= '0;
        end else if (commit_p0) begin
            cnt[tl_thread] <= cnt[tl_thread] + 32'd1;
        end
    end

    always_comb begin
        retire_cnt = '0;
        for (int i = 0; i < N_THREADS; i++) retire_cnt[i*32 +: 32] = cnt[i];
    end
`else
    logic unused_commit;
    assign unused_commit = commit_p0;
`endif

endmodule
